// File: rtl/seq_divider.sv
// Multi-cycle restoring divider that produces one quotient bit per clock, with valid/ready handshakes and a divide-by-zero flag.
// Define DIV_SIGNED_EN to add the signed_mode port, which selects two's-complement division that truncates toward zero.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
`ifdef DIV_SIGNED_EN
  ,
  input  logic             signed_mode
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dbz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dbz_o;

  logic               w_sa;
  logic               w_sb;
  logic               w_accept;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

`ifdef DIV_SIGNED_EN
  assign w_sa = signed_mode & a[WIDTH-1];
  assign w_sb = signed_mode & b[WIDTH-1];
`else
  assign w_sa = 1'b0;
  assign w_sb = 1'b0;
`endif

  assign w_accept = in_valid && r_in_ready;
  assign w_shift  = (r_acc << 1) | {{WIDTH{1'b0}}, r_q[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_div});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dbz_o     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_acc      <= '0;
            r_div      <= cond_neg(b, w_sb);
            r_cnt      <= CNT_W'(WIDTH);
            r_neg_q    <= w_sa ^ w_sb;
            r_neg_r    <= w_sa;
            // On divide-by-zero CALC is skipped, so r_q carries the raw dividend through to the remainder.
            if (b == '0) begin
              r_q     <= a;
              r_dbz   <= 1'b1;
              r_state <= S_FIX;
            end else begin
              r_q     <= cond_neg(a, w_sa);
              r_dbz   <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc <= w_ge ? (w_shift - {1'b0, r_div}) : w_shift;
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          // MIN/-1 yields magnitude 2^(WIDTH-1) with no negation, which reads back as MIN.
          if (r_dbz) begin
            r_quot  <= '1;
            r_rem   <= r_q;
            r_dbz_o <= 1'b1;
          end else begin
            r_quot  <= cond_neg(r_q, r_neg_q);
            r_rem   <= cond_neg(r_acc[WIDTH-1:0], r_neg_r);
            r_dbz_o <= 1'b0;
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz_o;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a table of hand-computed divisions, plus sequences for back-pressure,
// reset part-way through a division, and operands offered while the divider is busy.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
`ifdef DIV_SIGNED_EN
  logic         signed_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
`ifdef DIV_SIGNED_EN
    , .signed_mode(signed_mode)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one division and returns when out_valid is seen; lat counts cycles after the accept cycle.
  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb_, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got=0 expected=1");
    end
    a = ta; b = tb_; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_valid_timeout got=0 expected=1");
    end
  endtask

  initial begin
    int lat;
    bit bad;

    vecs[0]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dbz: 1'b0, lat: W + 2};
    vecs[1]  = '{a: 8'hFF,  b: 8'd1,   q: 8'hFF,  r: 8'd0,   dbz: 1'b0, lat: W + 2};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dbz: 1'b0, lat: W + 2};
    vecs[3]  = '{a: 8'h2A,  b: 8'd0,   q: 8'hFF,  r: 8'h2A,  dbz: 1'b1, lat: 2};
    vecs[4]  = '{a: 8'd200, b: 8'd3,   q: 8'd66,  r: 8'd2,   dbz: 1'b0, lat: W + 2};
    vecs[5]  = '{a: 8'd9,   b: 8'd2,   q: 8'd4,   r: 8'd1,   dbz: 1'b0, lat: W + 2};
    vecs[6]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dbz: 1'b0, lat: W + 2};
    vecs[7]  = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dbz: 1'b0, lat: W + 2};
    vecs[8]  = '{a: 8'd254, b: 8'd16,  q: 8'd15,  r: 8'd14,  dbz: 1'b0, lat: W + 2};
    vecs[9]  = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,   dbz: 1'b1, lat: 2};
    vecs[10] = '{a: 8'd17,  b: 8'd255, q: 8'd0,   r: 8'd17,  dbz: 1'b0, lat: W + 2};
    vecs[11] = '{a: 8'd128, b: 8'd128, q: 8'd1,   r: 8'd0,   dbz: 1'b0, lat: W + 2};

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    check("rst_in_ready_still_low", 32'(in_ready), 32'd0);
    tick();
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Table of directed vectors with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: result must hold for 20 cycles with in_ready low
    tick();
    out_ready = 1'b0;
    run_div(8'd200, 8'd3, lat);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (quotient !== 8'd66 || remainder !== 8'd2 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_quotient", 32'(quotient), 32'd66);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_out_valid_drop", 32'(out_valid), 32'd0);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);
    check("bp_outputs_kept", 32'(quotient), 32'd66);
    out_ready = 1'b1;

    // Operands offered while busy are ignored
    a = 8'd100; b = 8'd7; in_valid = 1'b1;
    tick();
    a = 8'd1; b = 8'd1;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    in_valid = 1'b0;
    check("busy_quotient", 32'(quotient), 32'd14);
    check("busy_remainder", 32'(remainder), 32'd2);
    check("busy_latency", 32'(lat), 32'(W + 2));
    tick();

    // Reset four cycles into CALC aborts the division
    a = 8'd100; b = 8'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    check("midrst_no_result", 32'(bad), 32'd0);
    run_div(8'd9, 8'd2, lat);
    check("postrst_quotient", 32'(quotient), 32'd4);
    check("postrst_remainder", 32'(remainder), 32'd1);
    tick();

`ifdef DIV_SIGNED_EN
    signed_mode = 1'b1;
    run_div(8'hF9, 8'd2, lat);
    check("s_m7_2_q", 32'(quotient), 32'hFD);
    check("s_m7_2_r", 32'(remainder), 32'hFF);
    tick();
    run_div(8'h80, 8'hFF, lat);
    check("s_min_m1_q", 32'(quotient), 32'h80);
    check("s_min_m1_r", 32'(remainder), 32'h00);
    check("s_min_m1_dbz", 32'(div_by_zero), 32'd0);
    tick();
    run_div(8'd7, 8'hFE, lat);
    check("s_7_m2_q", 32'(quotient), 32'hFD);
    check("s_7_m2_r", 32'(remainder), 32'h01);
    tick();
    run_div(8'hF9, 8'd0, lat);
    check("s_dbz_q", 32'(quotient), 32'hFF);
    check("s_dbz_r", 32'(remainder), 32'hF9);
    check("s_dbz_flag", 32'(div_by_zero), 32'd1);
    tick();
    signed_mode = 1'b0;
    run_div(8'hF9, 8'd2, lat);
    check("u_f9_2_q", 32'(quotient), 32'd124);
    check("u_f9_2_r", 32'(remainder), 32'd1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
